// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the host/loader port and the
// single-port data memory. The arbiter takes the slave view; whatever
// drives the requests and models the memory takes the master view.
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // CPU side
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_sb;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  // Host / loader side
  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  // Memory side
  logic          mem_en;
  logic          mem_we;
  logic          mem_sb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_sb, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_sb, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, a saturating starvation counter
// forces the host in periodically, and a bounded lock mode lets the host
// run burst loads while the CPU stalls. Requests reach the memory in the
// same cycle they are granted; read data returns one cycle later and is
// steered to whichever requester issued the read.
module dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic [LW-1:0] lock_cnt_reg, lock_cnt_next;
  // Read-return tag: bit 1 = CPU issued a read, bit 0 = host issued a read.
  logic [1:0]    rtag_reg, rtag_next;

  logic          hold;
  logic          cpu_gnt;
  logic          host_gnt;

  // Grant decision: an active lock burst wins, then the CPU unless the host
  // has been starved long enough, then the host.
  always_comb begin
    hold     = (state_reg == LOCK) & bus.host_req & bus.host_lock &
               (lock_cnt_reg < LOCK_TOP);
    cpu_gnt  = ~hold & bus.cpu_req & (starve_cnt_reg < STARVE_TOP);
    host_gnt = hold | (~cpu_gnt & bus.host_req);
  end

  // Next-state logic for lock FSM, starvation counter and read tag.
  always_comb begin
    state_next      = state_reg;
    lock_cnt_next   = lock_cnt_reg;
    starve_cnt_next = '0;
    rtag_next       = {cpu_gnt & ~bus.cpu_we, host_gnt & ~bus.host_we};

    case (state_reg)
      ARB: begin
        if (host_gnt && bus.host_lock) begin
          state_next    = LOCK;
          lock_cnt_next = LW'(1);
        end else begin
          lock_cnt_next = '0;
        end
      end
      LOCK: begin
        if (hold) begin
          lock_cnt_next = lock_cnt_reg + LW'(1);
        end else begin
          // Burst over: this cycle was arbitrated normally; always drop
          // back to ARB so a pending CPU gets its turn next.
          state_next    = ARB;
          lock_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ARB;
        lock_cnt_next = '0;
      end
    endcase

    if (bus.host_req && !host_gnt) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_TOP) ? starve_cnt_reg
                                                       : starve_cnt_reg + SW'(1);
    end
  end

  // State registers; reset drops any read return still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ARB;
      starve_cnt_reg <= '0;
      lock_cnt_reg   <= '0;
      rtag_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      lock_cnt_reg   <= lock_cnt_next;
      rtag_reg       <= rtag_next;
    end
  end

  // Memory-side mux of the granted requester; all zero when idle.
  always_comb begin
    bus.mem_en    = cpu_gnt | host_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_sb    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_sb    = bus.cpu_sb;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  // Requester-side outputs: stall/grant are combinational, read data is
  // gated so each side only sees memory data it asked for.
  always_comb begin
    bus.cpu_stall   = bus.cpu_req & ~cpu_gnt;
    bus.host_gnt    = host_gnt;
    bus.cpu_rvalid  = rtag_reg[1];
    bus.host_rvalid = rtag_reg[0];
    bus.cpu_rdata   = rtag_reg[1] ? bus.mem_rdata : '0;
    bus.host_rdata  = rtag_reg[0] ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small memory model answers reads, and
// each cycle's expected read return is queued and checked one cycle later.
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct packed {
    logic          cpu;
    logic          host;
    logic [DW-1:0] data;
  } ret_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic [DW-1:0] mem_array [0:255];
  ret_t          sb_q [$];

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(4), .LOCK_MAX(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous read, byte store writes only the low byte.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= 16'(i * 16'h0111) ^ 16'hA5A5;
      mem_array[16'h0010] <= 16'hBEEF;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        if (bus.mem_sb) mem_array[bus.mem_addr[7:0]][7:0] <= bus.mem_wdata[7:0];
        else            mem_array[bus.mem_addr[7:0]]      <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= mem_array[bus.mem_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_host(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_lock  = lock;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
  endtask

  task automatic idle_inputs();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, 1'b0, '0, '0);
    bus.cpu_sb = 1'b0;
  endtask

  // One cycle: inputs already driven just after a falling edge.
  // exp_owner: 0 = nobody, 1 = CPU, 2 = host.
  task automatic step(input int exp_owner, input string tag);
    ret_t          ret;
    ret_t          nxt;
    logic [34:0]   exp_mem;
    #1;
    ret = '0;
    if (sb_q.size() > 0) ret = sb_q.pop_front();
    check({tag, "/ret"},
          {30'd0, bus.cpu_rvalid, bus.host_rvalid, bus.cpu_rdata, bus.host_rdata},
          {30'd0, ret.cpu, ret.host, ret.cpu ? ret.data : 16'h0, ret.host ? ret.data : 16'h0});
    check({tag, "/gnt"},
          {61'd0, bus.host_gnt, bus.mem_en, bus.cpu_stall},
          {61'd0, exp_owner == 2, exp_owner != 0, bus.cpu_req & (exp_owner != 1)});
    case (exp_owner)
      1:       exp_mem = {1'b1, bus.cpu_we, bus.cpu_sb, bus.cpu_addr, bus.cpu_wdata};
      2:       exp_mem = {1'b1, bus.host_we, 1'b0, bus.host_addr, bus.host_wdata};
      default: exp_mem = '0;
    endcase
    check({tag, "/mem"},
          {29'd0, bus.mem_en, bus.mem_we, bus.mem_sb, bus.mem_addr, bus.mem_wdata},
          {29'd0, exp_mem});
    nxt.cpu  = (exp_owner == 1) && !bus.cpu_we;
    nxt.host = (exp_owner == 2) && !bus.host_we;
    nxt.data = nxt.cpu  ? mem_array[bus.cpu_addr[7:0]] :
               nxt.host ? mem_array[bus.host_addr[7:0]] : '0;
    sb_q.push_back(nxt);
    $display("[%0t] %s owner=%0d cpu_rv=%0b host_rv=%0b", $time, tag, exp_owner,
             bus.cpu_rvalid, bus.host_rvalid);
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    idle_inputs();
    @(negedge clk);
    step(0, "reset");
    reset = 1'b1;

    // CPU read returns BEEF one cycle later.
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    step(1, "cpu_rd");
    idle_inputs();
    step(0, "cpu_rd_ret");

    // Host write is word-wide and produces no read return; read it back.
    set_host(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
    step(2, "host_wr");
    idle_inputs();
    step(0, "host_wr_ret");
    set_host(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    step(2, "host_rd");
    idle_inputs();
    bus.cpu_sb = 1'b1;
    set_cpu(1'b1, 1'b1, 16'h0030, 16'h00C3);
    step(1, "cpu_sb_wr");
    idle_inputs();

    // Back-to-back reads alternating owners.
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i % 2 == 0) set_cpu(1'b1, 1'b0, 16'(16'h0040 + i), 16'h0);
      else            set_host(1'b1, 1'b0, 1'b0, 16'(16'h0080 + i), 16'h0);
      step((i % 2 == 0) ? 1 : 2, $sformatf("alt%0d", i));
    end
    idle_inputs();
    step(0, "alt_idle");

    // Both requesting without lock: CPU x4 then host x1, repeating.
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0);
      set_host(1'b1, 1'b0, 1'b0, 16'(16'h0060 + i), 16'h0);
      step((i % 5 == 4) ? 2 : 1, $sformatf("starve%0d", i));
    end
    idle_inputs();
    step(0, "starve_idle");

    // Short lock burst: host 3 cycles, CPU waits then gets cycle 3.
    for (int i = 0; i < 4; i++) begin
      set_cpu(i >= 1, 1'b0, 16'(16'h00A0 + i), 16'h0);
      set_host(i < 3, 1'b0, i < 3, 16'(16'h00B0 + i), 16'h0);
      step((i < 3) ? 2 : 1, $sformatf("lock%0d", i));
    end
    idle_inputs();
    step(0, "lock_idle");

    // Lock held with CPU pending: CPU x4, then host x8 / CPU x4 repeating.
    for (int i = 0; i < 30; i++) begin
      set_cpu(1'b1, 1'b0, 16'(16'h00C0 + i), 16'h0);
      set_host(1'b1, 1'b0, 1'b1, 16'(16'h00E0 + i), 16'h0);
      step((i < 4) ? 1 : ((((i - 4) % 12) < 8) ? 2 : 1), $sformatf("burst%0d", i));
    end
    idle_inputs();
    step(0, "burst_idle0");
    step(0, "burst_idle1");

    // Reset right after a granted CPU read, with starvation partly built up.
    for (int i = 0; i < 3; i++) begin
      set_cpu(1'b1, 1'b0, 16'(16'h0070 + i), 16'h0);
      set_host(1'b1, 1'b0, 1'b0, 16'(16'h0090 + i), 16'h0);
      step(1, $sformatf("pre_rst%0d", i));
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_drop",
          {30'd0, bus.cpu_rvalid, bus.host_rvalid, bus.cpu_rdata, bus.host_rdata}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    step(0, "in_reset");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cpu(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0);
      set_host(1'b1, 1'b0, 1'b0, 16'(16'h0050 + i), 16'h0);
      step((i == 4) ? 2 : 1, $sformatf("post_rst%0d", i));
    end
    idle_inputs();
    step(0, "final_idle");
    step(0, "final_idle2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
